// File: rtl/paddle_filter.sv
// Two-channel paddle position smoother: per-channel exponential filter with a
// deadband on the held position, plus frame-synchronous position/velocity latch.

module paddle_chan #(
  parameter int SHIFT    = 2,
  parameter int DEADBAND = 2,
  parameter int VMAX     = 31
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] raw,
  input  logic       stb,
  input  logic       frame,
  output logic [9:0] p,
  output logic [6:0] v
);
  localparam int W = 10 + SHIFT;
  localparam logic signed [10:0] VLIM = 11'(VMAX);
  localparam logic [10:0]        DBND = 11'(DEADBAND);

  typedef enum logic {INIT, TRACK} state_t;
  state_t state, state_nx;

  logic [W-1:0]       acc, acc_upd;
  logic [9:0]         f, h;
  logic               pend, seen;
  logic signed [10:0] dd, dv;
  logic [10:0]        mag;
  logic [6:0]         vsat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= INIT;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == INIT && stb) state_nx = TRACK;
  end

  always_comb begin
    f       = acc[W-1:SHIFT];
    // Intermediate sum may wrap; the subtraction brings it back into range.
    acc_upd = acc + W'(raw) - W'(f);
    dd      = $signed({1'b0, f}) - $signed({1'b0, h});
    mag     = dd[10] ? 11'(-dd) : 11'(dd);
    dv      = $signed({1'b0, h}) - $signed({1'b0, p});
    if (dv > VLIM)       vsat = 7'(VLIM);
    else if (dv < -VLIM) vsat = 7'(-VLIM);
    else                 vsat = dv[6:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc  <= '0;
      h    <= '0;
      pend <= 1'b0;
      seen <= 1'b0;
      p    <= '0;
      v    <= '0;
    end else begin
      pend <= stb && (state == TRACK);
      if (stb) acc <= (state == INIT) ? (W'(raw) << SHIFT) : acc_upd;
      // Deadband stage works on the acc value written one cycle earlier.
      if (stb && state == INIT)        h <= raw;
      else if (pend && (mag > DBND))   h <= f;
      if (frame && state == TRACK) begin
        p    <= h;
        v    <= seen ? vsat : '0;
        seen <= 1'b1;
      end
    end
  end
endmodule

module paddle_filter #(
  parameter int SHIFT    = 2,
  parameter int DEADBAND = 2,
  parameter int VMAX     = 31
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] raw_a,
  input  logic [9:0] raw_b,
  input  logic       stb_a,
  input  logic       stb_b,
  input  logic       frame,
  output logic [9:0] pa,
  output logic [9:0] pb,
  output logic [6:0] va,
  output logic [6:0] vb,
  output logic       upd
);
  paddle_chan #(.SHIFT(SHIFT), .DEADBAND(DEADBAND), .VMAX(VMAX)) u_a (
    .clk(clk), .reset_n(reset_n), .raw(raw_a), .stb(stb_a), .frame(frame),
    .p(pa), .v(va)
  );

  paddle_chan #(.SHIFT(SHIFT), .DEADBAND(DEADBAND), .VMAX(VMAX)) u_b (
    .clk(clk), .reset_n(reset_n), .raw(raw_b), .stb(stb_b), .frame(frame),
    .p(pb), .v(vb)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) upd <= 1'b0;
    else          upd <= frame;
  end
endmodule

// File: tb/tb_paddle_filter.sv
// Bench for paddle_filter: directed scenarios plus random traffic, every cycle
// compared against an integer reference model of the two channels.

module tb_paddle_filter;
  localparam int SHIFT = 2;
  localparam int DB    = 2;
  localparam int VMAX  = 31;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] raw_a = '0, raw_b = '0;
  logic       stb_a = 1'b0, stb_b = 1'b0, frame = 1'b0;
  logic [9:0] pa, pb;
  logic [6:0] va, vb;
  logic       upd;

  int n_checks = 0;
  int n_errors = 0;

  paddle_filter #(.SHIFT(SHIFT), .DEADBAND(DB), .VMAX(VMAX)) dut (
    .clk(clk), .reset_n(reset_n), .raw_a(raw_a), .raw_b(raw_b),
    .stb_a(stb_a), .stb_b(stb_b), .frame(frame),
    .pa(pa), .pb(pb), .va(va), .vb(vb), .upd(upd)
  );

  always #5 clk = ~clk;

  // Reference model state, index 0 = channel A, 1 = channel B.
  int m_acc[2], m_h[2], m_p[2], m_v[2], m_pf[2];
  bit m_trk[2], m_seen[2], m_pend[2];
  bit m_upd;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), exp);
    end
  endtask

  function automatic int clampv(input int d);
    if (d > VMAX)  return VMAX;
    if (d < -VMAX) return -VMAX;
    return d;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_acc[c] = 0; m_h[c] = 0; m_p[c] = 0; m_v[c] = 0; m_pf[c] = 0;
      m_trk[c] = 0; m_seen[c] = 0; m_pend[c] = 0;
    end
    m_upd = 0;
  endtask

  // One clock edge of the reference: all decisions use pre-edge values.
  task automatic model_step(input bit sa, input int ra, input bit sb, input int rb, input bit fr);
    bit s[2];
    int r[2];
    int nh, d;
    bit npend;
    s[0] = sa; s[1] = sb; r[0] = ra; r[1] = rb;
    for (int c = 0; c < 2; c++) begin
      nh = m_h[c];
      if (m_pend[c]) begin
        d = m_pf[c] - m_h[c];
        if (d > DB || d < -DB) nh = m_pf[c];
      end
      if (fr && m_trk[c]) begin
        m_v[c] = m_seen[c] ? clampv(m_h[c] - m_p[c]) : 0;
        m_p[c] = m_h[c];
        m_seen[c] = 1;
      end
      npend = 0;
      if (s[c]) begin
        if (!m_trk[c]) begin
          m_acc[c] = r[c] * (1 << SHIFT);
          nh = r[c];
          m_trk[c] = 1;
        end else begin
          m_acc[c] = m_acc[c] + r[c] - m_acc[c] / (1 << SHIFT);
          m_pf[c] = m_acc[c] / (1 << SHIFT);
          npend = 1;
        end
      end
      m_pend[c] = npend;
      m_h[c] = nh;
    end
    m_upd = fr;
  endtask

  task automatic compare_all();
    check("pa", 32'(pa), m_p[0]);
    check("pb", 32'(pb), m_p[1]);
    check("va", 32'($signed(va)), m_v[0]);
    check("vb", 32'($signed(vb)), m_v[1]);
    check("upd", 32'(upd), int'(m_upd));
  endtask

  // Called at negedge; drives one cycle of inputs and checks after the edge.
  task automatic cyc(input bit sa, input int ra, input bit sb, input int rb, input bit fr);
    stb_a = sa; raw_a = 10'(ra); stb_b = sb; raw_b = 10'(rb); frame = fr;
    @(posedge clk);
    model_step(sa, ra, sb, rb, fr);
    @(negedge clk);
    stb_a = 0; stb_b = 0; frame = 0;
    compare_all();
  endtask

  task automatic do_reset();
    reset_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    reset_n = 1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    cyc(0, 0, 0, 0, 0);

    // INIT load then frame: first frame gives zero velocity
    cyc(1, 400, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("init_pa", 32'(pa), 400);
    check("init_va", 32'($signed(va)), 0);
    check("init_pb", 32'(pb), 0);
    check("init_upd", 32'(upd), 1);
    cyc(0, 0, 0, 0, 0);
    check("upd_one", 32'(upd), 0);

    // Deadband hold then move
    cyc(1, 404, 0, 0, 0);
    cyc(1, 412, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("db_pa", 32'(pa), 403);
    check("db_va", 32'($signed(va)), 3);

    // Strobe coincident with frame latches the old h
    cyc(1, 500, 0, 0, 1);
    check("coinc_pa", 32'(pa), 403);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("coinc_next", 32'(pa), 428);

    // Velocity saturation for large rise and fall
    repeat (60) cyc(1, 100, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    repeat (60) cyc(1, 400, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("sat_pos", 32'($signed(va)), 31);
    repeat (60) cyc(1, 100, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("sat_neg", 32'($signed(va)), -31);

    // Simultaneous strobes on both channels
    cyc(0, 0, 1, 500, 0);
    cyc(1, 10, 1, 1000, 0);
    cyc(1, 10, 1, 1000, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    // Random traffic including back-to-back strobes and frames
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 1), $urandom_range(0, 1023),
          $urandom_range(0, 1), $urandom_range(0, 1023),
          $urandom_range(0, 7) == 0);

    // Asynchronous reset in the middle of a strobe pipeline
    cyc(1, 800, 1, 50, 0);
    cyc(1, 20, 0, 0, 1);
    #2 reset_n = 0;
    model_reset();
    #1;
    check("rst_pa", 32'(pa), 0);
    check("rst_pb", 32'(pb), 0);
    check("rst_va", 32'(va), 0);
    check("rst_vb", 32'(vb), 0);
    check("rst_upd", 32'(upd), 0);
    @(negedge clk);
    compare_all();
    reset_n = 1;
    cyc(1, 700, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    check("post_rst_pa", 32'(pa), 700);
    check("post_rst_va", 32'($signed(va)), 0);

    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 1), $urandom_range(0, 1023),
          $urandom_range(0, 1), $urandom_range(0, 1023),
          $urandom_range(0, 3) == 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
